mul_26x34_arb: RTL and testbench

//  Shares one pipelined 26x34 unsigned multiplier (TP = 1, fixed latency LAT) between two

---
 rtl/mul_26x34_arb.sv | 99 +++++++++
 tb/tb_mul_26x34_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_26x34_arb.sv
// rtl/mul_26x34_arb.sv - round-robin share of one pipelined 26x34 multiplier between two requesters
// Products return LAT cycles after issue, steered by a {valid,id} tag pipe that mirrors the multiplier.
module mul_26x34_arb #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        q0_valid,
  output logic        q0_ready,
  input  logic [25:0] q0_A,
  input  logic [33:0] q0_B,
  input  logic        q1_valid,
  output logic        q1_ready,
  input  logic [25:0] q1_A,
  input  logic [33:0] q1_B,
  output logic [25:0] mul_A,
  output logic [33:0] mul_B,
  input  logic [59:0] mul_C,
  output logic        r0_valid,
  output logic [59:0] r0_C,
  output logic        r1_valid,
  output logic [59:0] r1_C,
  output logic [1:0]  inflight
);

  logic           w_g0;
  logic           w_g1;
  logic           w_out_v;
  logic           w_out_id;
  logic [1:0]     w_cnt;
  logic           r_ptr;
  logic [LAT-1:0] r_v;
  logic [LAT-1:0] r_id;

  // r_ptr names the requester that wins the next conflict.
  always_comb begin
    w_g0 = en & ~rst & q0_valid & (~q1_valid | ~r_ptr);
    w_g1 = en & ~rst & q1_valid & (~q0_valid |  r_ptr);
  end

  assign q0_ready = w_g0;
  assign q1_ready = w_g1;

  always_comb begin
    mul_A = '0;
    mul_B = '0;
    if (w_g0) begin
      mul_A = q0_A;
      mul_B = q0_B;
    end else if (w_g1) begin
      mul_A = q1_A;
      mul_B = q1_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (w_g0) begin
      r_ptr <= 1'b1;
    end else if (w_g1) begin
      r_ptr <= 1'b0;
    end
  end

  // Tag pipe never stalls, so stage LAT-1 lines up with the product on mul_C.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v  <= '0;
      r_id <= '0;
    end else begin
      r_v[0]  <= w_g0 | w_g1;
      r_id[0] <= w_g1;
      for (int i = 1; i < LAT; i++) begin
        r_v[i]  <= r_v[i-1];
        r_id[i] <= r_id[i-1];
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < LAT; i++) begin
      w_cnt = w_cnt + {1'b0, r_v[i]};
    end
  end

  assign inflight = w_cnt;

  // Products still in the pipe while rst is high are dropped, not delivered.
  assign w_out_v  = r_v[LAT-1] & ~rst;
  assign w_out_id = r_id[LAT-1];
  assign r0_valid = w_out_v & ~w_out_id;
  assign r1_valid = w_out_v &  w_out_id;
  assign r0_C     = r0_valid ? mul_C : '0;
  assign r1_C     = r1_valid ? mul_C : '0;

endmodule

// File: tb/tb_mul_26x34_arb.sv
// tb/tb_mul_26x34_arb.sv - scoreboard bench for mul_26x34_arb with a behavioural multiplier
module tb_mul_26x34_arb;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        q0_valid, q1_valid;
  logic        q0_ready, q1_ready;
  logic [25:0] q0_A, q1_A;
  logic [33:0] q0_B, q1_B;
  logic [25:0] mul_A;
  logic [33:0] mul_B;
  logic [59:0] mul_C;
  logic        r0_valid, r1_valid;
  logic [59:0] r0_C, r1_C;
  logic [1:0]  inflight;

  mul_26x34_arb #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .q0_valid(q0_valid), .q0_ready(q0_ready), .q0_A(q0_A), .q0_B(q0_B),
    .q1_valid(q1_valid), .q1_ready(q1_ready), .q1_A(q1_A), .q1_B(q1_B),
    .mul_A(mul_A), .mul_B(mul_B), .mul_C(mul_C),
    .r0_valid(r0_valid), .r0_C(r0_C), .r1_valid(r1_valid), .r1_C(r1_C),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  logic [59:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= 60'(mul_A) * 60'(mul_B);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_C = mpipe[LAT-1];

  typedef struct {
    logic [59:0] c;
    int          due;
  } item_t;

  item_t       sq0[$];
  item_t       sq1[$];
  item_t       it;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          c0 = 0;
  int          c1 = 0;
  logic        m_ptr = 1'b0;
  logic        m_g0 = 1'b0;
  logic        m_g1 = 1'b0;
  logic [25:0] m_a;
  logic [33:0] m_b;
  logic [59:0] exp0, exp1;
  logic [31:0] ra, rb0, rb1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: model grant/ptr, check readys and operands, retire returned products.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_q0_ready", 64'(q0_ready), 64'd0);
      chk("rst_q1_ready", 64'(q1_ready), 64'd0);
      chk("rst_r_valid", 64'({r0_valid, r1_valid}), 64'd0);
      chk("rst_mul_A", 64'(mul_A), 64'd0);
      sq0.delete();
      sq1.delete();
      m_ptr = 1'b0;
      m_g0 = 1'b0;
      m_g1 = 1'b0;
    end else begin
      chk("inflight", 64'(inflight), 64'(sq0.size() + sq1.size()));
      if (r0_valid) begin
        if (sq0.size() == 0) chk("r0_spurious", 64'(r0_valid), 64'd0);
        else begin
          it = sq0.pop_front();
          chk("r0_C", 64'(r0_C), 64'(it.c));
          chk("r0_time", 64'(cyc), 64'(it.due));
        end
      end else chk("r0_C_idle", 64'(r0_C), 64'd0);
      if (r1_valid) begin
        if (sq1.size() == 0) chk("r1_spurious", 64'(r1_valid), 64'd0);
        else begin
          it = sq1.pop_front();
          chk("r1_C", 64'(r1_C), 64'(it.c));
          chk("r1_time", 64'(cyc), 64'(it.due));
        end
      end else chk("r1_C_idle", 64'(r1_C), 64'd0);
      if (sq0.size() > 0 && sq0[0].due <= cyc) begin
        chk("r0_missing", 64'(r0_valid), 64'd1);
        void'(sq0.pop_front());
      end
      if (sq1.size() > 0 && sq1[0].due <= cyc) begin
        chk("r1_missing", 64'(r1_valid), 64'd1);
        void'(sq1.pop_front());
      end
      m_g0 = en & q0_valid & (~q1_valid | ~m_ptr);
      m_g1 = en & q1_valid & (~q0_valid | m_ptr);
      m_a = m_g0 ? q0_A : (m_g1 ? q1_A : 26'd0);
      m_b = m_g0 ? q0_B : (m_g1 ? q1_B : 34'd0);
      chk("q0_ready", 64'(q0_ready), 64'(m_g0));
      chk("q1_ready", 64'(q1_ready), 64'(m_g1));
      chk("mul_A", 64'(mul_A), 64'(m_a));
      chk("mul_B", 64'(mul_B), 64'(m_b));
      if (q0_ready) c0++;
      if (q1_ready) c1++;
      if (m_g0) begin
        sq0.push_back('{c: exp0, due: cyc + LAT});
        m_ptr = 1'b1;
      end else if (m_g1) begin
        sq1.push_back('{c: exp1, due: cyc + LAT});
        m_ptr = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    q0_valid = 1'b1; q0_A = 26'd1; q0_B = 34'd1; exp0 = 60'd1;
    q1_valid = 1'b1; q1_A = 26'd1; q1_B = 34'd1; exp1 = 60'd1;
    step(3);
    q0_valid = 1'b0; q1_valid = 1'b0;
    rst = 1'b0;
    step(2);

    // 1: q0 streams all-ones operands
    q0_valid = 1'b1; q0_A = 26'h3FFFFFF; q0_B = 34'h3FFFFFFFF; exp0 = 60'hFFFFFFBFC000001;
    step(4);
    q0_valid = 1'b0;
    step(LAT + 2);

    // 2: both valid, strict alternation
    do_reset();
    c0 = 0; c1 = 0;
    q0_valid = 1'b1; q0_A = 26'd5; q0_B = 34'd7; exp0 = 60'd35;
    q1_valid = 1'b1; q1_A = 26'd3; q1_B = 34'd9; exp1 = 60'd27;
    step(20);
    q0_valid = 1'b0; q1_valid = 1'b0;
    chk("t2_q0_issues", 64'(c0), 64'd10);
    chk("t2_q1_issues", 64'(c1), 64'd10);
    step(LAT + 2);

    // 3: q1 alone then q0 joins
    q1_valid = 1'b1; q1_A = 26'd11; q1_B = 34'd13; exp1 = 60'd143;
    step(2);
    q0_valid = 1'b1; q0_A = 26'd2; q0_B = 34'd100; exp0 = 60'd200;
    step(6);
    q0_valid = 1'b0; q1_valid = 1'b0;
    step(LAT + 2);

    // 4: one issue then en low with both valid
    q0_valid = 1'b1; q0_A = 26'd1000; q0_B = 34'd1000; exp0 = 60'd1000000;
    step(1);
    en = 1'b0;
    q1_valid = 1'b1; q1_A = 26'd4; q1_B = 34'd4; exp1 = 60'd16;
    c0 = 0; c1 = 0;
    step(4);
    chk("t4_no_issue", 64'(c0 + c1), 64'd0);
    q0_valid = 1'b0; q1_valid = 1'b0; en = 1'b1;
    step(2);

    // 5: fill pipe then reset mid-flight
    q0_valid = 1'b1; q0_A = 26'd6; q0_B = 34'd6; exp0 = 60'd36;
    q1_valid = 1'b1; q1_A = 26'd8; q1_B = 34'd8; exp1 = 60'd64;
    step(LAT + 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(4);
    q0_valid = 1'b0; q1_valid = 1'b0;
    step(LAT + 2);

    // 6: random valid/en with operand hold while stalled
    for (int k = 0; k < 2000; k++) begin
      en = ($urandom_range(0, 9) != 0);
      if (!(q0_valid && !m_g0)) begin
        q0_valid = ($urandom_range(0, 9) < 6);
        ra = $urandom; rb0 = $urandom; rb1 = $urandom;
        q0_A = ra[25:0]; q0_B = {rb1[1:0], rb0};
        exp0 = 60'(q0_A) * 60'(q0_B);
      end
      if (!(q1_valid && !m_g1)) begin
        q1_valid = ($urandom_range(0, 9) < 6);
        ra = $urandom; rb0 = $urandom; rb1 = $urandom;
        q1_A = ra[25:0]; q1_B = {rb1[1:0], rb0};
        exp1 = 60'(q1_A) * 60'(q1_B);
      end
      step(1);
    end
    q0_valid = 1'b0; q1_valid = 1'b0;
    step(LAT + 3);
    chk("drain_q0", 64'(sq0.size()), 64'd0);
    chk("drain_q1", 64'(sq1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
